// File: rtl/adc_trigger_gen_pkg.sv
// Shared definitions for the ADC trigger timebase: register map, CTRL bit
// positions and the counter slope encoding.
package adc_trigger_gen_pkg;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_TOP      = 3'd1;
    localparam logic [2:0] ADDR_CMP      = 3'd2;
    localparam logic [2:0] ADDR_DIV      = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;
    localparam logic [2:0] ADDR_TRIG_CNT = 3'd5;

    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_UP_EN = 1;
    localparam int unsigned CTRL_DN_EN = 2;

    typedef enum logic {
        PH_UP = 1'b0,
        PH_DN = 1'b1
    } phase_e;

endpackage

// File: rtl/adc_trigger_gen_counter.sv
// Center-aligned up/down counter; boundary marks every edge that returns
// the count to zero (idle, top==0, or leaving 1 on the down slope).
module updown_counter
    import adc_trigger_gen_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run,
    input  logic [W-1:0] top,
    output logic [W-1:0] count,
    output phase_e       phase,
    output logic         boundary
);

    logic [W-1:0] count_nxt;
    phase_e       phase_nxt;

    always_comb begin
        count_nxt = count;
        phase_nxt = phase;
        boundary  = !run || (top == '0) || ((phase == PH_DN) && (count == W'(1)));
        if (boundary) begin
            count_nxt = '0;
            phase_nxt = PH_UP;
        end else begin
            case (phase)
                PH_UP: begin
                    if (count == top - W'(1)) begin
                        count_nxt = top;
                        phase_nxt = PH_DN;
                    end else begin
                        count_nxt = count + W'(1);
                    end
                end
                PH_DN: count_nxt = count - W'(1);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            phase <= PH_UP;
        end else begin
            count <= count_nxt;
            phase <= phase_nxt;
        end
    end

endmodule

// File: rtl/adc_trigger_gen.sv
// PWM-synchronous ADC trigger generator: register file, period shadows,
// decimation and compare around a center-aligned counter.
module adc_trigger_gen
    import adc_trigger_gen_pkg::*;
#(
    parameter int unsigned W           = 16,
    parameter int unsigned DEFAULT_TOP = 2500
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         MMS_read,
    input  logic         MMS_write,
    input  logic [2:0]   MMS_address,
    input  logic [31:0]  MMS_writedata,
    output logic [31:0]  MMS_readdata,
    output logic         trig_out,
    output logic         period_start,
    output logic [W-1:0] count_out
);

    logic         en, up_en, dn_en;
    logic [W-1:0] top_reg, cmp_reg;
    logic [7:0]   div_reg;
    logic [15:0]  trig_cnt;

    logic [W-1:0] top_sh, cmp_sh;
    logic [7:0]   div_sh, div_ctr;

    logic         wr_ctrl, wr_top, wr_cmp, wr_div, wr_trig_cnt;
    logic         en_next;
    logic [W-1:0] top_next, cmp_next;
    logic [7:0]   div_next;
    logic         run, boundary, match;
    logic [W-1:0] count;
    phase_e       phase;
    logic         unused_bits;

    assign wr_ctrl     = MMS_write && (MMS_address == ADDR_CTRL);
    assign wr_top      = MMS_write && (MMS_address == ADDR_TOP);
    assign wr_cmp      = MMS_write && (MMS_address == ADDR_CMP);
    assign wr_div      = MMS_write && (MMS_address == ADDR_DIV);
    assign wr_trig_cnt = MMS_write && (MMS_address == ADDR_TRIG_CNT);

    // Next-register values: shadows load these so a same-cycle write wins.
    assign en_next  = wr_ctrl ? MMS_writedata[CTRL_EN] : en;
    assign top_next = wr_top  ? MMS_writedata[W-1:0]   : top_reg;
    assign cmp_next = wr_cmp  ? MMS_writedata[W-1:0]   : cmp_reg;
    assign div_next = wr_div  ? MMS_writedata[7:0]     : div_reg;

    // Disable acts on the writing edge; enable restarts from a held zero.
    assign run = en && en_next;

    updown_counter #(.W(W)) u_counter (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .top      (top_sh),
        .count    (count),
        .phase    (phase),
        .boundary (boundary)
    );

    assign match = run && (top_sh != '0) && (count == cmp_sh) && (div_ctr == '0) &&
                   (((phase == PH_UP) && up_en) || ((phase == PH_DN) && dn_en));

    always_ff @(posedge clk) begin
        if (reset) begin
            en       <= 1'b0;
            up_en    <= 1'b0;
            dn_en    <= 1'b0;
            top_reg  <= W'(DEFAULT_TOP);
            cmp_reg  <= '0;
            div_reg  <= '0;
            top_sh   <= W'(DEFAULT_TOP);
            cmp_sh   <= '0;
            div_sh   <= '0;
            div_ctr  <= '0;
            trig_out <= 1'b0;
            trig_cnt <= '0;
        end else begin
            en      <= en_next;
            top_reg <= top_next;
            cmp_reg <= cmp_next;
            div_reg <= div_next;
            if (wr_ctrl) begin
                up_en <= MMS_writedata[CTRL_UP_EN];
                dn_en <= MMS_writedata[CTRL_DN_EN];
            end
            if (boundary) begin
                top_sh <= top_next;
                cmp_sh <= cmp_next;
                div_sh <= div_next;
            end
            if (!run) begin
                div_ctr <= '0;
            end else if (boundary && (top_sh != '0)) begin
                div_ctr <= (div_ctr == div_sh) ? '0 : div_ctr + 8'd1;
            end
            trig_out <= match;
            if (wr_trig_cnt) begin
                trig_cnt <= '0;
            end else if (trig_out) begin
                trig_cnt <= trig_cnt + 16'd1;
            end
        end
    end

    assign period_start = en && (count == '0);
    assign count_out    = count;

    always_comb begin
        MMS_readdata = '0;
        case (MMS_address)
            ADDR_CTRL: begin
                MMS_readdata[CTRL_EN]    = en;
                MMS_readdata[CTRL_UP_EN] = up_en;
                MMS_readdata[CTRL_DN_EN] = dn_en;
            end
            ADDR_TOP:      MMS_readdata[W-1:0] = top_reg;
            ADDR_CMP:      MMS_readdata[W-1:0] = cmp_reg;
            ADDR_DIV:      MMS_readdata[7:0]   = div_reg;
            ADDR_STATUS: begin
                MMS_readdata[W-1:0] = count;
                MMS_readdata[31]    = (phase == PH_DN);
            end
            ADDR_TRIG_CNT: MMS_readdata[15:0]  = trig_cnt;
            default:       MMS_readdata = '0;
        endcase
    end

    // Reads have no side effects; upper write-data bits have no home.
    assign unused_bits = ^{MMS_read, MMS_writedata};

endmodule

// File: tb/tb_adc_trigger_gen.sv
// Directed bench for adc_trigger_gen with hand-derived expected waveforms.
module tb_adc_trigger_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        MMS_read;
    logic        MMS_write;
    logic [2:0]  MMS_address;
    logic [31:0] MMS_writedata;
    logic [31:0] MMS_readdata;
    logic        trig_out;
    logic        period_start;
    logic [15:0] count_out;

    int total = 0;
    int bad   = 0;

    adc_trigger_gen #(.W(16), .DEFAULT_TOP(2500)) dut (
        .clk           (clk),
        .reset         (reset),
        .MMS_read      (MMS_read),
        .MMS_write     (MMS_write),
        .MMS_address   (MMS_address),
        .MMS_writedata (MMS_writedata),
        .MMS_readdata  (MMS_readdata),
        .trig_out      (trig_out),
        .period_start  (period_start),
        .count_out     (count_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        MMS_write     = 1'b1;
        MMS_address   = a;
        MMS_writedata = d;
        tick();
        MMS_write     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        MMS_read    = 1'b1;
        MMS_address = a;
        #1;
        d        = MMS_readdata;
        MMS_read = 1'b0;
    endtask

    function automatic int tri_val(int n, int top);
        int p;
        p = n % (2 * top);
        return (p < top) ? p : 2 * top - p;
    endfunction

    initial begin
        logic [31:0] d;
        logic        e;

        reset = 1'b1; MMS_read = 1'b0; MMS_write = 1'b0;
        MMS_address = '0; MMS_writedata = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_count", 32'(count_out), 32'd0);
        check("rst_trig", 32'(trig_out), 32'd0);
        check("rst_pstart", 32'(period_start), 32'd0);
        rd(3'd1, d); check("rst_top", d, 32'd2500);
        rd(3'd0, d); check("rst_ctrl", d, 32'd0);

        // Basic up/down, TOP=4 CMP=1, both slopes
        wr(3'd1, 32'd4); wr(3'd2, 32'd1); wr(3'd0, 32'd6); wr(3'd0, 32'd7);
        for (int c = 0; c <= 16; c++) begin
            check("basic_count", 32'(count_out), 32'(tri_val(c, 4)));
            e = (c % 8 == 2) || (c % 8 == 0 && c > 0);
            check("basic_trig", 32'(trig_out), 32'(e));
            check("basic_pstart", 32'(period_start), 32'(c % 8 == 0));
            if (c == 5) begin
                rd(3'd4, d); check("status_down", d, 32'h8000_0003);
            end
            if (c == 2) begin
                rd(3'd4, d); check("status_up", d, 32'h0000_0002);
            end
            tick();
        end

        // Decimation DIV=2, up only
        wr(3'd0, 32'd2); wr(3'd3, 32'd2); wr(3'd5, 32'd0); wr(3'd0, 32'd3);
        for (int c = 0; c < 60; c++) begin
            e = (c == 2) || (c == 26) || (c == 50);
            check("div_trig", 32'(trig_out), 32'(e));
            tick();
        end
        rd(3'd5, d); check("div_trig_cnt", d, 32'd3);

        // Shadowed TOP
        wr(3'd0, 32'd6); wr(3'd3, 32'd0); wr(3'd0, 32'd7);
        for (int c = 0; c < 3; c++) begin
            check("sh_count", 32'(count_out), 32'(tri_val(c, 4)));
            tick();
        end
        check("sh_count3", 32'(count_out), 32'd3);
        wr(3'd1, 32'd6);
        for (int c = 4; c < 31; c++) begin
            check("sh_count", 32'(count_out), 32'((c < 8) ? tri_val(c, 4) : tri_val(c - 8, 6)));
            tick();
        end
        check("sh_count31", 32'(count_out), 32'd1);
        wr(3'd1, 32'd4);
        for (int c = 32; c <= 40; c++) begin
            check("sh_wrwin", 32'(count_out), 32'(tri_val(c - 32, 4)));
            tick();
        end

        // Edge compare values
        for (int k = 0; k < 3; k++) begin
            int cmpv;
            cmpv = (k == 0) ? 0 : (k == 1) ? 4 : 5;
            wr(3'd0, 32'd6); wr(3'd2, 32'(cmpv)); wr(3'd0, 32'd7);
            for (int c = 0; c < 24; c++) begin
                e = (k == 0) ? (c % 8 == 1) : (k == 1) ? (c % 8 == 5) : 1'b0;
                check("edge_trig", 32'(trig_out), 32'(e));
                tick();
            end
        end

        // Disable in the match cycle
        wr(3'd0, 32'd6); wr(3'd2, 32'd1); wr(3'd0, 32'd7);
        check("dis_c0", 32'(count_out), 32'd0);
        tick();
        check("dis_c1", 32'(count_out), 32'd1);
        wr(3'd0, 32'd6);
        check("dis_trig", 32'(trig_out), 32'd0);
        check("dis_count", 32'(count_out), 32'd0);
        check("dis_pstart", 32'(period_start), 32'd0);
        tick();
        check("dis_trig2", 32'(trig_out), 32'd0);
        wr(3'd0, 32'd7);
        check("reen_count", 32'(count_out), 32'd0);
        check("reen_pstart", 32'(period_start), 32'd1);
        tick(); tick();
        check("reen_count2", 32'(count_out), 32'd2);
        check("reen_trig", 32'(trig_out), 32'd1);

        // Reset mid-period, asserted in a match cycle
        wr(3'd0, 32'd6); wr(3'd0, 32'd7); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("mrst_trig", 32'(trig_out), 32'd0);
        check("mrst_count", 32'(count_out), 32'd0);
        check("mrst_pstart", 32'(period_start), 32'd0);
        rd(3'd1, d); check("mrst_top", d, 32'd2500);
        rd(3'd2, d); check("mrst_cmp", d, 32'd0);
        rd(3'd6, d); check("unmapped", d, 32'd0);

        // TRIG_CNT clear coincident with a pulse
        wr(3'd1, 32'd4); wr(3'd2, 32'd1); wr(3'd0, 32'd3);
        tick(); tick();
        check("clr_trig", 32'(trig_out), 32'd1);
        wr(3'd5, 32'd0);
        rd(3'd5, d); check("clr_cnt", d, 32'd0);
        for (int c = 3; c < 11; c++) tick();
        rd(3'd5, d); check("clr_cnt_after", d, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_trigger_gen.md
Name: adc_trigger_gen

Overview:
- Center-aligned PWM-synchronous timebase that produces the single-cycle `trig_out` pulse feeding the ADC sequencer's trigger input.
- Sits directly upstream of the ADC sequencer; the trigger instant is placed at a programmable counter value on the up slope, the down slope or both.
- Optional period decimation fires only every (DIV+1)-th PWM period.
- Configured over the same small Avalon-MM slave style as the sequencer; period-affecting registers are shadowed and take effect only at period start.

Parameters:
- W, 16, counter/TOP/CMP width (2..16)
- DEFAULT_TOP, 2500, reset value of the TOP register

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- MMS_read  in  1  avalon slave read (no side effects)
- MMS_write  in  1  avalon slave write
- MMS_address  in  3  register index
- MMS_writedata  in  32  write data
- MMS_readdata  out  32  combinational read data, zero-filled
- trig_out  out  1  registered one-cycle trigger pulse to the sequencer
- period_start  out  1  high while EN=1 and count==0
- count_out  out  W  live counter value

Behaviour:
- One clock. Reset is synchronous and active-high; ports are named clk and reset.
- Register map (unlisted bits and addresses 6-7 read 0):
  - 0 CTRL: [0] EN, [1] UP_EN, [2] DN_EN; reset 0.
  - 1 TOP: [W-1:0]; reset DEFAULT_TOP.
  - 2 CMP: [W-1:0]; reset 0.
  - 3 DIV: [7:0]; reset 0.
  - 4 STATUS (read-only): [W-1:0] count, [31] phase (1 = down).
  - 5 TRIG_CNT: [15:0] wrapping count of trig_out pulses; any write clears it.
- Reset values: count=0, phase=up, div_ctr=0, trig_out=0, TRIG_CNT=0, shadows top_sh/cmp_sh/div_sh = reset register values.
- EN=0:
  - count held at 0, phase up, div_ctr 0, trig_out 0 next edge.
  - Shadows load every cycle.
- Counting with EN=1 and top_sh>0:
  - Up phase visits 0..top_sh-1. Leaving top_sh-1 gives count=top_sh and phase=down.
  - Down phase visits top_sh..1. Leaving 1 gives count=0 and phase=up.
  - Period is 2*top_sh cycles. Value 0 is up-only; value top_sh is down-only.
- top_sh==0: count held at 0, phase up, no triggers. Shadows reload every cycle, so a later TOP write starts counting.
- Period boundary is every edge that sets count to 0, including the edge where EN goes 0->1. On that edge:
  - top_sh/cmp_sh/div_sh load from TOP/CMP/DIV. A write in the same cycle is loaded, i.e. the write wins.
  - div_ctr is set to 0 if div_ctr==div_sh, else div_ctr+1. On the EN rising edge, div_ctr is set to 0.
- Qualified period: div_ctr==0 during that period.
- Match: count==cmp_sh and (phase up and UP_EN, or phase down and DN_EN) and qualified period and EN. trig_out goes high exactly one cycle after the match cycle, for one cycle.
- cmp_sh>top_sh never matches. cmp_sh==0 can fire only on up; cmp_sh==top_sh only on down.
- Writing EN=0 in a match cycle suppresses that pulse. Mid-period disable is immediate; re-enable restarts from count 0.
- UP_EN/DN_EN are not shadowed and act on the next compare.
- TRIG_CNT:
  - Increments on each trig_out=1 cycle, wrapping 0xFFFF->0.
  - A write in the same cycle as a pulse leaves 0.
- Writes to read-only or unmapped addresses are ignored.

Decomposition:
- Shared package holds the register address constants (CTRL, TOP, CMP, DIV, STATUS, TRIG_CNT) and the CTRL bit positions.
- One natural sub-module, `updown_counter`: count/phase/top_sh==0 handling, exposing a boundary strobe.
- Register file, shadows, decimation and compare stay in the top.

Test Plan:
- Basic up/down triggers: TOP=4, CMP=1, UP_EN=DN_EN=1, then EN=1. With cycle 0 as the first count==0 cycle, count must read 0,1,2,3,4,3,2,1,0; trig_out is high in cycles 2 and 8, then repeats every 8 cycles; period_start is high in cycles 0, 8, 16.
- Decimation: same setup, DIV=2, UP_EN only. trig_out is high in cycles 2, 26, 50 and nowhere else; TRIG_CNT reads 3 at cycle 60.
- Shadowing: TOP=4 running, write TOP=6 in cycle 3. Count still turns at 4; the next period peaks at 6 (length 12). Writing TOP=6 exactly in a count==1 down cycle takes effect immediately at the next 0.
- Edge compares: CMP=0 gives up-only pulses with DN_EN ignored; CMP=TOP=4 gives down-only pulses; CMP=5 with TOP=4 gives no pulses for 3 periods.
- Disable in match cycle: write EN=0 in cycle 1. No pulse; count=0 next cycle; re-enable restarts with cycle 0 at count 0 and div_ctr=0.
- Reset and clear: assert reset mid-period; all outputs are 0 next cycle and TOP reads 2500. A TRIG_CNT write coincident with a trig_out pulse leaves TRIG_CNT=0.
